// File: rtl/stars_ctrl_pkg.sv
// Shared types for the RV32I control decoder and its decode queue.
//   inst_type_t  : instruction class derived from the opcode
//   fop_t        : ALU function code carried in the control word (5 bits)
//   ctrl_word_t  : packed control word (ALU op, branch type, control bits, illegal flag)
//   OPC_* / BR_* : opcode and branch_type constants
package stars_ctrl_pkg;

  typedef enum logic [3:0] {
    IT_R, IT_I, IT_LOAD, IT_STORE, IT_BRANCH, IT_JAL, IT_JALR, IT_LUI, IT_AUIPC, IT_BAD
  } inst_type_t;

  typedef enum logic [4:0] {
    FOP_ADD  = 5'd0,  FOP_SUB  = 5'd1,  FOP_SLL  = 5'd2,  FOP_XOR  = 5'd3,
    FOP_SRL  = 5'd4,  FOP_SRA  = 5'd5,  FOP_OR   = 5'd6,  FOP_AND  = 5'd7,
    FOP_ADDI = 5'd8,  FOP_SLLI = 5'd9,  FOP_XORI = 5'd10, FOP_SRLI = 5'd11,
    FOP_SRAI = 5'd12, FOP_ORI  = 5'd13, FOP_ANDI = 5'd14, FOP_IMM  = 5'd15,
    FOP_SLT  = 5'd17, FOP_SLTU = 5'd18
  } fop_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_UNC  = 3'd7;

  typedef struct packed {
    fop_t       alu_op;
    logic [2:0] branch_type;
    logic       reg_write_en;
    logic       alu_mux_en;
    logic       store_byte;
    logic       load_byte;
    logic       mem_to_reg;
    logic       write_mem;
    logic       read_mem;
    logic       pc_absolute_jump_vec;
    logic       read_next_pc;
    logic       illegal;
  } ctrl_word_t;

  function automatic inst_type_t classify(input logic [6:0] opc);
    case (opc)
      OPC_R:      return IT_R;
      OPC_I:      return IT_I;
      OPC_LOAD:   return IT_LOAD;
      OPC_STORE:  return IT_STORE;
      OPC_BRANCH: return IT_BRANCH;
      OPC_JAL:    return IT_JAL;
      OPC_JALR:   return IT_JALR;
      OPC_LUI:    return IT_LUI;
      OPC_AUIPC:  return IT_AUIPC;
      default:    return IT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Pure combinational RV32I instruction -> control word decoder.
//   instr_i : raw 32-bit instruction
//   ctrl_o  : decoded control word; illegal encodings give illegal=1, alu_op=FOP_ADD,
//             every other field 0
// HAS_SLT=0 treats the SLT/SLTU/SLTI/SLTIU encodings as illegal.
module rv32_ctrl_decode
  import stars_ctrl_pkg::*;
#(
  parameter bit HAS_SLT = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_word_t  ctrl_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  ctrl_word_t cw;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  // Register and immediate fields do not affect control.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    cw    = '0;
    cw.alu_op = FOP_ADD;
    legal = 1'b1;
    case (classify(opc))
      IT_R: begin
        cw.reg_write_en = 1'b1;
        // Only SUB and SRA use funct7=0100000.
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        case (f3)
          3'b000: cw.alu_op = f7[5] ? FOP_SUB : FOP_ADD;
          3'b001: cw.alu_op = FOP_SLL;
          3'b010: begin cw.alu_op = FOP_SLT;  if (!HAS_SLT) legal = 1'b0; end
          3'b011: begin cw.alu_op = FOP_SLTU; if (!HAS_SLT) legal = 1'b0; end
          3'b100: cw.alu_op = FOP_XOR;
          3'b101: cw.alu_op = f7[5] ? FOP_SRA : FOP_SRL;
          3'b110: cw.alu_op = FOP_OR;
          default: cw.alu_op = FOP_AND;
        endcase
      end
      IT_I: begin
        cw.reg_write_en = 1'b1;
        cw.alu_mux_en   = 1'b1;
        case (f3)
          3'b000: cw.alu_op = FOP_ADDI;
          3'b001: begin cw.alu_op = FOP_SLLI; legal = (f7 == 7'h00); end
          3'b010: begin cw.alu_op = FOP_SLT;  if (!HAS_SLT) legal = 1'b0; end
          3'b011: begin cw.alu_op = FOP_SLTU; if (!HAS_SLT) legal = 1'b0; end
          3'b100: cw.alu_op = FOP_XORI;
          3'b101: begin
            cw.alu_op = f7[5] ? FOP_SRAI : FOP_SRLI;
            legal     = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'b110: cw.alu_op = FOP_ORI;
          default: cw.alu_op = FOP_ANDI;
        endcase
      end
      IT_LOAD: begin
        cw.read_mem     = 1'b1;
        cw.mem_to_reg   = 1'b1;
        cw.reg_write_en = 1'b1;
        cw.alu_mux_en   = 1'b1;
        cw.alu_op       = FOP_ADDI;
        cw.load_byte    = (f3 == 3'b000) || (f3 == 3'b100);
        legal           = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b010);
      end
      IT_STORE: begin
        cw.write_mem  = 1'b1;
        cw.alu_mux_en = 1'b1;
        cw.alu_op     = FOP_ADDI;
        cw.store_byte = (f3 == 3'b000);
        legal         = (f3 == 3'b000) || (f3 == 3'b010);
      end
      IT_BRANCH: begin
        cw.alu_op = FOP_SUB;
        case (f3)
          3'b000:  cw.branch_type = BR_BEQ;
          3'b001:  cw.branch_type = BR_BNE;
          3'b100:  cw.branch_type = BR_BLT;
          3'b101:  cw.branch_type = BR_BGE;
          3'b110:  cw.branch_type = BR_BLTU;
          3'b111:  cw.branch_type = BR_BGEU;
          default: legal = 1'b0;
        endcase
      end
      IT_JAL: begin
        cw.branch_type  = BR_UNC;
        cw.read_next_pc = 1'b1;
        cw.reg_write_en = 1'b1;
      end
      IT_JALR: begin
        cw.branch_type          = BR_UNC;
        cw.read_next_pc         = 1'b1;
        cw.reg_write_en         = 1'b1;
        cw.pc_absolute_jump_vec = 1'b1;
        cw.alu_mux_en           = 1'b1;
        cw.alu_op               = FOP_ADDI;
        legal                   = (f3 == 3'b000);
      end
      IT_LUI: begin
        cw.alu_op       = FOP_IMM;
        cw.alu_mux_en   = 1'b1;
        cw.reg_write_en = 1'b1;
      end
      IT_AUIPC: begin
        cw.alu_op       = FOP_ADDI;
        cw.alu_mux_en   = 1'b1;
        cw.reg_write_en = 1'b1;
        cw.read_next_pc = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal words collapse to a NOP-like ADD with only the flag raised.
    if (!legal) begin
      cw         = '0;
      cw.alu_op  = FOP_ADD;
      cw.illegal = 1'b1;
    end
  end

  assign ctrl_o = cw;

endmodule

// File: rtl/decode_ctrl_queue.sv
// Decodes RV32I instructions and buffers the control words in a DEPTH-entry FIFO
// between fetch and execute.
//   clk, nrst (sync, active low), flush
//   in_valid/in_ready/instruction       : fetch side
//   out_valid/out_ready + control bits  : head of the queue, all 0 when empty
//   illegal_count                       : saturating count of accepted illegal words
module decode_ctrl_queue
  import stars_ctrl_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter bit HAS_SLT = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       alu_op,
  output logic [2:0]       branch_type,
  output logic             reg_write_en,
  output logic             alu_mux_en,
  output logic             store_byte,
  output logic             load_byte,
  output logic             mem_to_reg,
  output logic             write_mem,
  output logic             read_mem,
  output logic             pc_absolute_jump_vec,
  output logic             read_next_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  ctrl_word_t       dec_w;
  ctrl_word_t       mem_q [DEPTH];
  ctrl_word_t       head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push, pop;

  rv32_ctrl_decode #(.HAS_SLT(HAS_SLT)) u_dec (
    .instr_i (instruction),
    .ctrl_o  (dec_w)
  );

  // A full queue still accepts when the head drains in the same cycle.
  assign in_ready  = nrst & ((count_q < FULL) | out_ready);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (push && dec_w.illegal && (ill_cnt_q != {CNT_W{1'b1}}))
        ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_w;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign alu_op               = head.alu_op;
  assign branch_type          = head.branch_type;
  assign reg_write_en         = head.reg_write_en;
  assign alu_mux_en           = head.alu_mux_en;
  assign store_byte           = head.store_byte;
  assign load_byte            = head.load_byte;
  assign mem_to_reg           = head.mem_to_reg;
  assign write_mem            = head.write_mem;
  assign read_mem             = head.read_mem;
  assign pc_absolute_jump_vec = head.pc_absolute_jump_vec;
  assign read_next_pc         = head.read_next_pc;
  assign illegal              = head.illegal;
  assign illegal_count        = ill_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Bench for decode_ctrl_queue: two instances share one stimulus stream
// (u0: HAS_SLT=0, CNT_W=2; u1: HAS_SLT=1, CNT_W=8). A queue of raw instructions
// models the FIFO; heads are decoded by an independent rule table and compared every cycle.
module tb_decode_ctrl_queue;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, flush, in_valid, out_ready;
  logic [31:0] instruction;

  logic       ir0, ov0, rwe0, amux0, sb0, lb0, m2r0, wm0, rm0, pca0, rnp0, ill0;
  logic [4:0] alu0;
  logic [2:0] br0;
  logic [1:0] ic0;
  logic       ir1, ov1, rwe1, amux1, sb1, lb1, m2r1, wm1, rm1, pca1, rnp1, ill1;
  logic [4:0] alu1;
  logic [2:0] br1;
  logic [7:0] ic1;

  decode_ctrl_queue #(.DEPTH(D), .HAS_SLT(1'b0), .CNT_W(2)) u0 (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .instruction(instruction), .out_valid(ov0), .out_ready(out_ready),
    .alu_op(alu0), .branch_type(br0), .reg_write_en(rwe0), .alu_mux_en(amux0),
    .store_byte(sb0), .load_byte(lb0), .mem_to_reg(m2r0), .write_mem(wm0),
    .read_mem(rm0), .pc_absolute_jump_vec(pca0), .read_next_pc(rnp0),
    .illegal(ill0), .illegal_count(ic0));

  decode_ctrl_queue #(.DEPTH(D), .HAS_SLT(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .instruction(instruction), .out_valid(ov1), .out_ready(out_ready),
    .alu_op(alu1), .branch_type(br1), .reg_write_en(rwe1), .alu_mux_en(amux1),
    .store_byte(sb1), .load_byte(lb1), .mem_to_reg(m2r1), .write_mem(wm1),
    .read_mem(rm1), .pc_absolute_jump_vec(pca1), .read_next_pc(rnp1),
    .illegal(ill1), .illegal_count(ic1));

  logic [17:0] v0, v1;
  assign v0 = {ill0, alu0, br0, rwe0, amux0, sb0, lb0, m2r0, wm0, rm0, pca0, rnp0};
  assign v1 = {ill1, alu1, br1, rwe1, amux1, sb1, lb1, m2r1, wm1, rm1, pca1, rnp1};

  localparam logic [31:0] I_ADD   = 32'h003100B3, I_SUB   = 32'h403100B3;
  localparam logic [31:0] I_SLT   = 32'h003120B3, I_SLTU  = 32'h003130B3;
  localparam logic [31:0] I_LB    = 32'h00010083, I_SW    = 32'h00312023;
  localparam logic [31:0] I_BEQ   = 32'h00208063, I_ADDI  = 32'h00510093;
  localparam logic [31:0] I_SRAI  = 32'h40315093, I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7, I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097, I_ONES  = 32'hFFFFFFFF;
  localparam logic [31:0] I_BADBR = 32'h0020A063, I_BADST = 32'h00313023;
  localparam logic [31:0] I_BADSH = 32'h40311093, I_SLTI  = 32'h00512093;
  localparam logic [31:0] I_BLTU  = 32'h0020E063, I_LW    = 32'h00012083;
  localparam logic [31:0] I_SB    = 32'h00310023, I_SRA   = 32'h403150B3;

  logic [31:0] q[$];
  int mcnt0, mcnt1;
  int total = 0, bad = 0;

  // Expected head fields from the ISA rules:
  // {illegal, alu_op[4:0], branch_type[2:0], rwe, amux, sb, lb, m2r, wm, rm, pcabs, rnpc}
  function automatic logic [17:0] mdl(input logic [31:0] ins, input bit slt);
    int op, f3, f7, alu, br;
    logic [8:0] b;
    bit ok;
    int ralu [8] = '{0, 2, 17, 18, 3, 4, 6, 7};
    int ialu [8] = '{8, 9, 17, 18, 10, 11, 13, 14};
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    alu = 0; br = 0; b = '0; ok = 1'b0;
    case (op)
      'h33: begin
        ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
        alu = ralu[f3];
        if (f7 == 'h20) alu = (f3 == 0) ? 1 : 5;
        if ((f3 == 2 || f3 == 3) && !slt) ok = 1'b0;
        b = 9'b100000000;
      end
      'h13: begin
        ok = 1'b1; alu = ialu[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = (f7 == 0 || f7 == 'h20); if (f7 == 'h20) alu = 12; end
        if ((f3 == 2 || f3 == 3) && !slt) ok = 1'b0;
        b = 9'b110000000;
      end
      'h03: begin
        ok = (f3 == 0 || f3 == 4 || f3 == 2); alu = 8;
        b = {1'b1, 1'b1, 1'b0, (f3 != 2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      end
      'h23: begin
        ok = (f3 == 0 || f3 == 2); alu = 8;
        b = {1'b0, 1'b1, (f3 == 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      end
      'h63: begin ok = (f3 != 2 && f3 != 3); alu = 1; br = (f3 < 2) ? f3 + 1 : f3 - 1; end
      'h6F: begin ok = 1'b1; br = 7; b = 9'b100000001; end
      'h67: begin ok = (f3 == 0); br = 7; alu = 8; b = 9'b110000011; end
      'h37: begin ok = 1'b1; alu = 15; b = 9'b110000000; end
      'h17: begin ok = 1'b1; alu = 8;  b = 9'b110000001; end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 17'b0};
    return {1'b0, alu[4:0], br[2:0], b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic cyc();
    bit rdy, push, pop;
    logic [17:0] e0, e1;
    #1;
    rdy = nrst && ((q.size() < D) || out_ready);
    chk("in_ready0", ir0, rdy);
    chk("in_ready1", ir1, rdy);
    pop  = (q.size() != 0) && out_ready;
    push = in_valid && rdy && !flush;
    @(posedge clk);
    if (!nrst) begin
      q.delete(); mcnt0 = 0; mcnt1 = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(instruction);
        if (mdl(instruction, 1'b0) >> 17) mcnt0 = (mcnt0 < 3)   ? mcnt0 + 1 : 3;
        if (mdl(instruction, 1'b1) >> 17) mcnt1 = (mcnt1 < 255) ? mcnt1 + 1 : 255;
      end
    end
    @(negedge clk);
    e0 = (q.size() != 0) ? mdl(q[0], 1'b0) : '0;
    e1 = (q.size() != 0) ? mdl(q[0], 1'b1) : '0;
    chk("out_valid0", ov0, q.size() != 0);
    chk("out_valid1", ov1, q.size() != 0);
    chk("head0", v0, e0);
    chk("head1", v1, e1);
    chk("ill_cnt0", ic0, mcnt0);
    chk("ill_cnt1", ic1, mcnt1);
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit r, input bit f);
    in_valid = v; instruction = ins; out_ready = r; flush = f;
    cyc();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mix [12];
    mix = '{I_SUB, I_SLTU, I_SLTI, I_BLTU, I_LW, I_SB, I_SRA, I_JALR,
            I_ADDI, I_SRAI, I_LUI, I_BEQ};
    mcnt0 = 0; mcnt1 = 0;
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    step(1, I_ADD, 1, 0);
    step(0, I_ADD, 0, 0);
    chk("rst_ov", ov0, 0);
    chk("rst_ic", ic1, 0);
    nrst = 1'b1;

    // 1: single ADD, one cycle latency
    step(1, I_ADD, 1, 0);
    chk("t1_ov", ov0, 1);
    chk("t1_alu", alu0, 0);
    chk("t1_rwe", rwe0, 1);
    chk("t1_vec", v0, 18'h00100);
    step(0, 0, 1, 0);

    // 2: fill with out_ready low, third accept refused
    step(1, I_LB, 0, 0);
    step(1, I_SW, 0, 0);
    in_valid = 1'b1; instruction = I_BEQ; #1;
    chk("t2_full_rdy", ir0, 0);
    step(1, I_BEQ, 0, 0);
    chk("t2_lb", lb0, 1);
    chk("t2_rm", rm0, 1);
    chk("t2_m2r", m2r0, 1);
    step(0, 0, 1, 0);
    chk("t2_wm", wm0, 1);
    chk("t2_sb", sb0, 0);
    step(0, 0, 1, 0);

    // 3: full queue streaming, pointers wrap
    step(1, I_ADDI, 0, 0);
    step(1, I_SRAI, 0, 0);
    step(1, I_JAL, 1, 0);
    step(1, I_JALR, 1, 0);
    step(1, I_LUI, 1, 0);
    step(1, I_AUIPC, 1, 0);
    chk("t3_ov", ov1, 1);
    chk("t3_alu", alu1, 15);
    step(0, 0, 1, 0);
    chk("t3_rnp", rnp1, 1);
    step(0, 0, 1, 0);

    // 5: illegal words and counter saturation
    step(1, I_ONES, 1, 0);
    step(1, I_SLT, 1, 0);
    chk("t5_ill0", ill0, 1);
    chk("t5_alu0", alu0, 0);
    chk("t5_alu1", alu1, 17);
    step(0, 0, 1, 0);
    chk("t5_cnt0", ic0, 2);
    chk("t5_cnt1", ic1, 1);
    step(1, I_BADBR, 1, 0);
    step(1, I_BADST, 1, 0);
    step(1, I_BADSH, 1, 0);
    step(0, 0, 1, 0);
    chk("t5_sat0", ic0, 3);
    chk("t5_cnt1b", ic1, 4);

    // 4: flush with two entries and an illegal word on the input
    step(1, I_ADD, 0, 0);
    step(1, I_SUB, 0, 0);
    step(1, I_ONES, 1, 1);
    chk("t4_ov", ov0, 0);
    chk("t4_cnt1", ic1, 4);
    step(0, 0, 1, 0);

    // mixed traffic with intermittent back-pressure
    for (int i = 0; i < 12; i++) step(1, mix[i], (i % 3) != 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // 6: reset with a full queue
    step(1, I_LB, 0, 0);
    step(1, I_SW, 0, 0);
    nrst = 1'b0;
    step(1, I_ADD, 1, 0);
    chk("t6_ov", ov0, 0);
    chk("t6_rdy", ir1, 0);
    chk("t6_cnt", ic1, 0);
    step(1, I_ADD, 1, 0);
    nrst = 1'b1;
    step(1, I_JAL, 1, 0);
    chk("t6_br", br0, 7);
    step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
